// File: rtl/my_de0_nano_pkg.sv
// Shared definitions for the DE0-Nano 16-bit RISC slice: opcodes, instruction
// field positions and the built-in default program image.
package my_de0_nano_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_idx_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_LDI  = 4'h5,
    OP_LW   = 4'h6,
    OP_SW   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RS_MSB = 8;
  localparam int RS_LSB = 6;
  localparam int RT_MSB = 5;
  localparam int RT_LSB = 3;

  localparam word_t HALT_WORD = 16'hF000;
  localparam int    PROG_LEN  = 7;

  // Stores 7 to address 96, then 1 to address 55, then spins on word 6.
  localparam word_t DEFAULT_PROG [PROG_LEN] = '{
    16'h5260,  // LDI r1,96
    16'h5407,  // LDI r2,7
    16'h7440,  // SW  r2,0(r1)
    16'h5637,  // LDI r3,55
    16'h5801,  // LDI r4,1
    16'h78C0,  // SW  r4,0(r3)
    16'h9006   // JMP 6
  };

  function automatic word_t default_rom_word(input int unsigned addr);
    if (addr < PROG_LEN) return DEFAULT_PROG[addr];
    return HALT_WORD;
  endfunction

endpackage

// File: rtl/rv16_core.sv
// Single-cycle 16-bit RISC core: PC, eight-entry register file, decoder, ALU
// and the data-memory bus outputs (forced idle while reset is high).
module rv16_core
  import my_de0_nano_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  word_t       instr,
  input  word_t       read_data,
  output logic [7:0]  pc,
  output logic        mem_write,
  output logic [12:0] data_adr,
  output word_t       write_data
);

  word_t    regs [8];
  opcode_e  op;
  reg_idx_t rd_a, rs_a, rt_a;
  word_t    rd_val, rs_val, rt_val;
  word_t    imm6_sx, imm9_sx;
  word_t    alu, wb_val;
  logic     wb_en, store;
  logic [7:0] next_pc;

  assign op      = opcode_e'(instr[OP_MSB:OP_LSB]);
  assign rd_a    = instr[RD_MSB:RD_LSB];
  assign rs_a    = instr[RS_MSB:RS_LSB];
  assign rt_a    = instr[RT_MSB:RT_LSB];
  assign imm6_sx = {{10{instr[5]}}, instr[5:0]};
  assign imm9_sx = {{7{instr[8]}}, instr[8:0]};

  assign rd_val = (rd_a == '0) ? '0 : regs[rd_a];
  assign rs_val = (rs_a == '0) ? '0 : regs[rs_a];
  assign rt_val = (rt_a == '0) ? '0 : regs[rt_a];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    alu     = '0;
    wb_en   = 1'b0;
    store   = 1'b0;
    next_pc = pc + 8'd1;
    case (op)
      OP_ADD:  begin alu = rs_val + rt_val;  wb_en = 1'b1; end
      OP_SUB:  begin alu = rs_val - rt_val;  wb_en = 1'b1; end
      OP_AND:  begin alu = rs_val & rt_val;  wb_en = 1'b1; end
      OP_OR:   begin alu = rs_val | rt_val;  wb_en = 1'b1; end
      OP_ADDI: begin alu = rs_val + imm6_sx; wb_en = 1'b1; end
      OP_LDI:  begin alu = imm9_sx;          wb_en = 1'b1; end
      OP_LW:   begin alu = rs_val + imm6_sx; wb_en = 1'b1; end
      OP_SW:   begin alu = rs_val + imm6_sx; store = 1'b1; end
      OP_BEQ:  if (rd_val == rs_val) next_pc = pc + 8'd1 + imm6_sx[7:0];
      OP_JMP:  next_pc = instr[7:0];
      OP_HALT: next_pc = pc;
      default: ;
    endcase
  end

  // Load data is muxed outside the ALU block so the RAM read path does not
  // feed back into the block that produces the address.
  assign wb_val = (op == OP_LW) ? read_data : alu;

  assign mem_write  = store & ~rst;
  assign data_adr   = rst ? '0 : alu[12:0];
  assign write_data = (store && !rst) ? rd_val : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, matching the hardware regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (wb_en && rd_a != '0) regs[rd_a] <= wb_val;
    end
  end

endmodule

// File: rtl/my_de0_nano.sv
// DE0-Nano top: instruction ROM, data RAM, rv16_core and the GPIO bus monitor.
// The ROM holds the built-in default image from my_de0_nano_pkg.
module my_de0_nano
  import my_de0_nano_pkg::*;
#(
  parameter int ROM_WORDS = 256,
  parameter int RAM_WORDS = 256
) (
  input logic        CLOCK_50,
  inout wire  [33:0] GPIO_0_PI,
  inout wire  [33:0] GPIO_1,
  inout wire  [12:0] GPIO_2
);

  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);

  typedef word_t rom_t [ROM_WORDS];

  logic        rst;
  logic [7:0]  pc;
  word_t       instr, read_data, write_data;
  logic        mem_write;
  logic [12:0] data_adr;
  logic        unused_gpio0;

  assign rst          = GPIO_0_PI[1];
  assign unused_gpio0 = ^{GPIO_0_PI[33:2], GPIO_0_PI[0]};

  function automatic rom_t default_image();
    for (int i = 0; i < ROM_WORDS; i++) default_image[i] = default_rom_word(i);
  endfunction

  rom_t rom = default_image();

  assign instr = rom[pc[ROM_AW-1:0]];

  // NOTE: the RAM has no reset; contents survive a core reset and only the
  // elaboration-time zero fill defines its start state.
  word_t ram [RAM_WORDS] = '{default: '0};

  always_ff @(posedge CLOCK_50) begin
    if (mem_write) ram[data_adr[RAM_AW-1:0]] <= write_data;
  end

  assign read_data = ram[data_adr[RAM_AW-1:0]];

  rv16_core u_core (
    .clk        (CLOCK_50),
    .rst        (rst),
    .instr      (instr),
    .read_data  (read_data),
    .pc         (pc),
    .mem_write  (mem_write),
    .data_adr   (data_adr),
    .write_data (write_data)
  );

  assign GPIO_1 = {mem_write, 1'b0, read_data, write_data};
  assign GPIO_2 = data_adr;

endmodule

// File: tb/tb_my_de0_nano.sv
// Directed bench for my_de0_nano: default program stores, reset behaviour,
// then a patched ROM image exercising LW, r0, wrap-around ADD and BEQ.
module tb_my_de0_nano;

  typedef struct {
    int          cyc;
    logic [12:0] adr;
    logic [15:0] data;
  } store_t;

  logic        clk = 1'b0;
  logic        rst;
  wire  [33:0] gpio_0;
  wire  [33:0] gpio_1;
  wire  [12:0] gpio_2;

  store_t sb[$];
  int     cyc;
  int     checks = 0;
  int     errors = 0;

  assign gpio_0 = {32'd0, rst, 1'b0};

  my_de0_nano dut (
    .CLOCK_50  (clk),
    .GPIO_0_PI (gpio_0),
    .GPIO_1    (gpio_1),
    .GPIO_2    (gpio_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle's bus, retires any store against the scoreboard,
  // then advances to the start of the next cycle.
  task automatic step();
    store_t e;
    #1;
    cyc++;
    if (gpio_1[33]) begin
      if (sb.size() == 0) begin
        check("unexpected_store", {31'd0, gpio_1[33]}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("store_cycle", cyc, e.cyc);
        check("store_adr", {19'd0, gpio_2}, {19'd0, e.adr});
        check("store_data", {16'd0, gpio_1[15:0]}, {16'd0, e.data});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cyc = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_memwrite", {31'd0, gpio_1[33]}, 32'd0);
    check("rst_dataadr", {19'd0, gpio_2}, 32'd0);
    check("rst_writedata", {16'd0, gpio_1[15:0]}, 32'd0);
    check("rst_bit32", {31'd0, gpio_1[32]}, 32'd0);

    // Default program: two stores, then spinning on JMP.
    rst = 1'b0;
    cyc = 0;
    sb.push_back('{3, 13'd96, 16'd7});
    sb.push_back('{6, 13'd55, 16'd1});
    repeat (12) step();
    check("default_all_stores_seen", sb.size(), 32'd0);

    // Restart, then reset again during cycle 4.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    sb.push_back('{3, 13'd96, 16'd7});
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("c4_rst_memwrite", {31'd0, gpio_1[33]}, 32'd0);
    check("c4_rst_dataadr", {19'd0, gpio_2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    sb.push_back('{3, 13'd96, 16'd7});
    sb.push_back('{6, 13'd55, 16'd1});
    repeat (7) step();
    check("restart_all_stores_seen", sb.size(), 32'd0);

    // Reset landing on the SW cycle must suppress that store.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    check("sw_rst_memwrite", {31'd0, gpio_1[33]}, 32'd0);
    check("sw_rst_writedata", {16'd0, gpio_1[15:0]}, 32'd0);
    check("sw_rst_dataadr", {19'd0, gpio_2}, 32'd0);

    // Patched image while reset is held.
    dut.rom[0]  = 16'h5260;  // LDI r1,96
    dut.rom[1]  = 16'h6A40;  // LW  r5,0(r1)
    dut.rom[2]  = 16'h7A01;  // SW  r5,1(r0)
    dut.rom[3]  = 16'h5005;  // LDI r0,5
    dut.rom[4]  = 16'h7002;  // SW  r0,2(r0)
    dut.rom[5]  = 16'h5DFF;  // LDI r6,-1
    dut.rom[6]  = 16'h4E01;  // ADDI r7,r0,1
    dut.rom[7]  = 16'h0DB8;  // ADD r6,r6,r7
    dut.rom[8]  = 16'h7C03;  // SW  r6,3(r0)
    dut.rom[9]  = 16'h53FF;  // LDI r1,-1
    dut.rom[10] = 16'h7240;  // SW  r1,0(r1)
    dut.rom[11] = 16'h827F;  // BEQ r1,r1,-1
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    sb.push_back('{3, 13'd1, 16'd7});
    sb.push_back('{5, 13'd2, 16'd0});
    sb.push_back('{9, 13'd3, 16'd0});
    sb.push_back('{11, 13'h1FFF, 16'hFFFF});
    step();
    #1;
    check("lw_dataadr", {19'd0, gpio_2}, 32'd96);
    check("lw_readdata", {16'd0, gpio_1[31:16]}, 32'd7);
    check("lw_memwrite", {31'd0, gpio_1[33]}, 32'd0);
    repeat (6) step();
    #1;
    check("add_wrap_adr", {19'd0, gpio_2}, 32'd0);
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("beq_pc_hold", {24'd0, dut.u_core.pc}, 32'd11);
      step();
    end
    check("image_all_stores_seen", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
